// File: rtl/ah_mux_pkg.sv
// Shared definitions for the AH one-hot mux family: occupancy encoding,
// state type and a select-legality helper.
package ah_mux_pkg;

  // Widest select vector the legality helper handles; callers zero-extend.
  localparam int AH_MAX_CH = 64;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY = OCC_EMPTY,
    ST_ONE   = OCC_ONE,
    ST_FULL  = OCC_FULL
  } occ_state_t;

  // True when exactly one bit of sel is set (nonzero and a power of two).
  function automatic logic ah_onehot_ok(input logic [AH_MAX_CH-1:0] sel);
    return (sel != '0) && ((sel & (sel - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/ah_onehot_mux_pipe_if.sv
// Upstream/downstream handshake bundle for the pipelined one-hot mux.
// slave is the mux side, master is the side driving beats and ready.
interface ah_onehot_mux_pipe_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 8
);
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        mux_select;
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_sel_err;
  logic                     out_valid;
  logic                     out_ready;
  logic                     err_sticky;
  logic                     err_clr;

  modport slave (
    input  in_data, mux_select, in_valid, out_ready, err_clr,
    output in_ready, out_data, out_sel_err, out_valid, err_sticky
  );

  modport master (
    output in_data, mux_select, in_valid, out_ready, err_clr,
    input  in_ready, out_data, out_sel_err, out_valid, err_sticky
  );
endinterface

// File: rtl/ah_onehot_andor.sv
// Combinational NUM_CH x DATA_W AND-OR reduction. Zero-hot yields 0 and
// multi-hot yields the bitwise OR of the selected channels; sel_err flags
// any select that is not exactly one-hot. NUM_CH must not exceed AH_MAX_CH.
module ah_onehot_andor
  import ah_mux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 8
) (
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        sel,
  output logic [DATA_W-1:0]        data,
  output logic                     sel_err
);

  // OR together every channel whose select bit is set, and check legality.
  always_comb begin
    data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel[k]) data = data | in_data[k*DATA_W +: DATA_W];
    end
    sel_err = !ah_onehot_ok(AH_MAX_CH'(sel));
  end

endmodule

// File: rtl/ah_onehot_mux_pipe.sv
// Pipelined one-hot mux with a 2-entry skid buffer. The main register drives
// the outputs; the skid register catches the beat accepted while the output
// is stalled so in_ready can be fully registered.
module ah_onehot_mux_pipe
  import ah_mux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 8
) (
  input logic              clk,
  input logic              rst,
  ah_onehot_mux_pipe_if.slave bus
);

  occ_state_t        state;
  logic [DATA_W-1:0] main_data;
  logic              main_err;
  logic [DATA_W-1:0] skid_data;
  logic              skid_err;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              err_sticky_q;

  logic [DATA_W-1:0] mux_data;
  logic              mux_err;
  logic              accept;
  logic              transfer;

  ah_onehot_andor #(
    .DATA_W(DATA_W),
    .NUM_CH(NUM_CH)
  ) u_andor (
    .in_data(bus.in_data),
    .sel    (bus.mux_select),
    .data   (mux_data),
    .sel_err(mux_err)
  );

  assign accept   = bus.in_valid & in_ready_q;
  assign transfer = out_valid_q & bus.out_ready;

  // Occupancy FSM: moves beats into main/skid and keeps ready/valid registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_EMPTY;
      main_data   <= '0;
      main_err    <= 1'b0;
      skid_data   <= '0;
      skid_err    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            main_data   <= mux_data;
            main_err    <= mux_err;
            out_valid_q <= 1'b1;
            state       <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && !transfer) begin
            skid_data  <= mux_data;
            skid_err   <= mux_err;
            in_ready_q <= 1'b0;
            state      <= ST_FULL;
          end else if (accept && transfer) begin
            main_data <= mux_data;
            main_err  <= mux_err;
          end else if (transfer) begin
            out_valid_q <= 1'b0;
            state       <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (transfer) begin
            main_data  <= skid_data;
            main_err   <= skid_err;
            in_ready_q <= 1'b1;
            state      <= ST_ONE;
          end
        end
        default: begin
          state       <= ST_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flag; a new illegal accepted select beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky_q <= 1'b0;
    end else if (accept && mux_err) begin
      err_sticky_q <= 1'b1;
    end else if (bus.err_clr) begin
      err_sticky_q <= 1'b0;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = main_data;
  assign bus.out_sel_err = main_err;
  assign bus.err_sticky  = err_sticky_q;

endmodule

// File: tb/tb_ah_onehot_mux_pipe.sv
// Self-checking bench for ah_onehot_mux_pipe in the default 8x8 shape and a
// 32-bit x 5-channel shape, driven from a vector table plus directed sequences.
module tb_ah_onehot_mux_pipe;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  ah_onehot_mux_pipe_if #(.DATA_W(8),  .NUM_CH(8)) bus8 ();
  ah_onehot_mux_pipe_if #(.DATA_W(32), .NUM_CH(5)) bus32 ();

  ah_onehot_mux_pipe #(.DATA_W(8), .NUM_CH(8)) dut8 (
    .clk(clk),
    .rst(rst),
    .bus(bus8)
  );

  ah_onehot_mux_pipe #(.DATA_W(32), .NUM_CH(5)) dut32 (
    .clk(clk),
    .rst(rst),
    .bus(bus32)
  );

  typedef struct {
    logic [7:0]  sel;
    logic [63:0] data;
    logic        clr;
    logic [7:0]  exp_data;
    logic        exp_err;
    logic        exp_sticky;
  } vec_t;

  vec_t vecs [9];

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge so registered outputs are settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] sel, input logic [63:0] data,
                               input logic valid, input logic rdy, input logic clr);
    bus8.mux_select = sel;
    bus8.in_data    = data;
    bus8.in_valid   = valid;
    bus8.out_ready  = rdy;
    bus8.err_clr    = clr;
  endtask

  task automatic applyStimulus32(input logic [4:0] sel, input logic [159:0] data,
                                 input logic valid, input logic rdy, input logic clr);
    bus32.mux_select = sel;
    bus32.in_data    = data;
    bus32.in_valid   = valid;
    bus32.out_ready  = rdy;
    bus32.err_clr    = clr;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [63:0] rnd_data;
    logic [7:0]  rnd_exp [100];
    int          idx;

    tests_run    = 0;
    tests_failed = 0;

    vecs[0] = '{8'h04, 64'h1122334455A56677, 1'b0, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 64'h1122334455A56677, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[2] = '{8'h81, 64'hF00000000000000F, 1'b0, 8'hFF, 1'b1, 1'b1};
    vecs[3] = '{8'h01, 64'h1122334455A56677, 1'b1, 8'h77, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 64'h1122334455A56677, 1'b0, 8'h11, 1'b0, 1'b0};
    vecs[5] = '{8'h06, 64'h1122334455A56677, 1'b1, 8'hE7, 1'b1, 1'b1};
    vecs[6] = '{8'h10, 64'h1122334455A56677, 1'b1, 8'h44, 1'b0, 1'b0};
    vecs[7] = '{8'hFF, 64'h1122334455A56677, 1'b0, 8'hF7, 1'b1, 1'b1};
    vecs[8] = '{8'h20, 64'h1122334455A56677, 1'b1, 8'h33, 1'b0, 1'b0};

    // Reset held two cycles with beats offered on both instances.
    rst = 1'b1;
    applyStimulus(8'h04, 64'h1122334455A56677, 1'b1, 1'b1, 1'b0);
    applyStimulus32(5'h01, {5{32'h12345678}}, 1'b1, 1'b1, 1'b0);
    step();
    step();
    checkOutput("rst out_valid", 32'(bus8.out_valid), 32'd0);
    checkOutput("rst in_ready", 32'(bus8.in_ready), 32'd1);
    checkOutput("rst out_data", 32'(bus8.out_data), 32'h00);
    checkOutput("rst out_sel_err", 32'(bus8.out_sel_err), 32'd0);
    checkOutput("rst err_sticky", 32'(bus8.err_sticky), 32'd0);
    checkOutput("rst32 out_valid", 32'(bus32.out_valid), 32'd0);
    checkOutput("rst32 out_data", bus32.out_data, 32'h0);
    rst = 1'b0;
    applyStimulus(8'h00, 64'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus32(5'h00, 160'h0, 1'b0, 1'b1, 1'b0);
    step();

    // Single beats from EMPTY: mux result, legality and sticky/clear priority.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].sel, vecs[i].data, 1'b1, 1'b1, vecs[i].clr);
      step();
      applyStimulus(8'h00, 64'h0, 1'b0, 1'b1, 1'b0);
      checkOutput($sformatf("vec%0d out_valid", i), 32'(bus8.out_valid), 32'd1);
      checkOutput($sformatf("vec%0d out_data", i), 32'(bus8.out_data), 32'(vecs[i].exp_data));
      checkOutput($sformatf("vec%0d out_sel_err", i), 32'(bus8.out_sel_err), 32'(vecs[i].exp_err));
      checkOutput($sformatf("vec%0d err_sticky", i), 32'(bus8.err_sticky), 32'(vecs[i].exp_sticky));
      step();
    end
    checkOutput("idle out_valid", 32'(bus8.out_valid), 32'd0);
    checkOutput("idle holds out_data", 32'(bus8.out_data), 32'h33);

    // Streaming 100 random one-hot beats: one beat per cycle, in order.
    for (int i = 0; i < 100; i++) begin
      rnd_data = {$urandom, $urandom};
      idx = $urandom_range(0, 7);
      rnd_exp[i] = rnd_data[idx*8 +: 8];
      applyStimulus(8'(1 << idx), rnd_data, 1'b1, 1'b1, 1'b0);
      step();
      checkOutput($sformatf("stream%0d out_valid", i), 32'(bus8.out_valid), 32'd1);
      checkOutput($sformatf("stream%0d out_data", i), 32'(bus8.out_data), 32'(rnd_exp[i]));
      checkOutput($sformatf("stream%0d in_ready", i), 32'(bus8.in_ready), 32'd1);
    end
    applyStimulus(8'h00, 64'h0, 1'b0, 1'b1, 1'b0);
    step();
    checkOutput("stream drain out_valid", 32'(bus8.out_valid), 32'd0);

    // Backpressure: two accepts fill the buffer, third beat waits upstream.
    applyStimulus(8'h01, 64'h11, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("bp1 in_ready", 32'(bus8.in_ready), 32'd1);
    applyStimulus(8'h01, 64'h22, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("bp2 in_ready", 32'(bus8.in_ready), 32'd0);
    checkOutput("bp2 out_data", 32'(bus8.out_data), 32'h11);
    applyStimulus(8'h01, 64'h33, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("bp3 in_ready", 32'(bus8.in_ready), 32'd0);
    checkOutput("bp3 out_valid", 32'(bus8.out_valid), 32'd1);
    checkOutput("bp3 out_data held", 32'(bus8.out_data), 32'h11);
    applyStimulus(8'h01, 64'h33, 1'b1, 1'b1, 1'b0);
    step();
    checkOutput("bp rel1 out_data", 32'(bus8.out_data), 32'h22);
    checkOutput("bp rel1 in_ready", 32'(bus8.in_ready), 32'd1);
    step();
    applyStimulus(8'h00, 64'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("bp rel2 out_data", 32'(bus8.out_data), 32'h33);
    checkOutput("bp rel2 out_valid", 32'(bus8.out_valid), 32'd1);
    step();
    checkOutput("bp drained out_valid", 32'(bus8.out_valid), 32'd0);

    // Reset while FULL: the skid beat must never appear.
    applyStimulus(8'h02, 64'hAA00, 1'b1, 1'b0, 1'b0);
    step();
    applyStimulus(8'h02, 64'hBB00, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("full in_ready", 32'(bus8.in_ready), 32'd0);
    rst = 1'b1;
    applyStimulus(8'h02, 64'hCC00, 1'b1, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    applyStimulus(8'h00, 64'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("rstfull out_valid", 32'(bus8.out_valid), 32'd0);
    checkOutput("rstfull in_ready", 32'(bus8.in_ready), 32'd1);
    checkOutput("rstfull out_data", 32'(bus8.out_data), 32'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput($sformatf("rstfull idle%0d out_valid", i), 32'(bus8.out_valid), 32'd0);
    end

    // 32-bit x 5-channel instance: legal, zero-hot, multi-hot selects.
    applyStimulus32(5'h04, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0}, 1'b1, 1'b1, 1'b0);
    step();
    checkOutput("w32 legal out_data", bus32.out_data, 32'hDEADBEEF);
    checkOutput("w32 legal out_sel_err", 32'(bus32.out_sel_err), 32'd0);
    applyStimulus32(5'h00, {5{32'h5A5A5A5A}}, 1'b1, 1'b1, 1'b0);
    step();
    checkOutput("w32 zero out_data", bus32.out_data, 32'h0);
    checkOutput("w32 zero out_sel_err", 32'(bus32.out_sel_err), 32'd1);
    checkOutput("w32 zero err_sticky", 32'(bus32.err_sticky), 32'd1);
    applyStimulus32(5'h11, {32'hFFFF0000, 32'h1, 32'h2, 32'h4, 32'h0000FFFF}, 1'b1, 1'b1, 1'b0);
    step();
    checkOutput("w32 multi out_data", bus32.out_data, 32'hFFFFFFFF);
    checkOutput("w32 multi out_sel_err", 32'(bus32.out_sel_err), 32'd1);
    applyStimulus32(5'h00, 160'h0, 1'b0, 1'b1, 1'b0);
    step();
    checkOutput("w32 drain out_valid", 32'(bus32.out_valid), 32'd0);

    // 32-bit instance backpressure ordering.
    applyStimulus32(5'h10, {32'h11111111, 128'h0}, 1'b1, 1'b0, 1'b0);
    step();
    applyStimulus32(5'h10, {32'h22222222, 128'h0}, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("w32 bp in_ready", 32'(bus32.in_ready), 32'd0);
    applyStimulus32(5'h10, {32'h33333333, 128'h0}, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("w32 bp held", bus32.out_data, 32'h11111111);
    applyStimulus32(5'h10, {32'h33333333, 128'h0}, 1'b1, 1'b1, 1'b0);
    step();
    checkOutput("w32 bp rel1", bus32.out_data, 32'h22222222);
    step();
    applyStimulus32(5'h00, 160'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("w32 bp rel2", bus32.out_data, 32'h33333333);
    step();
    checkOutput("w32 bp drained", 32'(bus32.out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
